// File: rtl/mult_share_arb.sv
// Round-robin arbiter that time-shares one signed 8-bit multiplier among NREQ requesters
// and returns each product over a per-requester valid/ready response channel.
module mult_share_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MULT_LAT = 2,
  parameter int unsigned IDW      = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [7:0]          rsp_data,
  output logic [IDW-1:0]      rsp_id,
  output logic [7:0]          mult_a,
  output logic [7:0]          mult_b,
  input  logic [7:0]          mult_res,
  output logic                busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] CAPT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam int unsigned CW = $clog2(MULT_LAT + 1);

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [7:0]      mult_a_q, mult_a_d;
  logic [7:0]      mult_b_q, mult_b_d;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  sc_idx;
  int unsigned     scan;
  logic [7:0]      sel_a, sel_b;

  // Scan from the requester after the last winner, wrapping, and take the first valid one.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
    sc_idx    = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      scan = 32'(rr_ptr_q) + i;
      if (scan >= NREQ) scan = scan - NREQ;
      sc_idx = scan[IDW-1:0];
      if (!gnt_found && req_valid[sc_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = sc_idx;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt_idx == IDW'(k)) begin
        sel_a = req_a[8*k +: 8];
        sel_b = req_b[8*k +: 8];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && gnt_found) req_ready = NREQ'(1) << gnt_idx;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    mult_a_d    = mult_a_q;
    mult_b_d    = mult_b_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          mult_a_d = sel_a;
          mult_b_d = sel_b;
          rsp_id_d = gnt_idx;
          rr_ptr_d = gnt_idx;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(MULT_LAT - 1)) state_d = CAPT;
      end
      CAPT: begin
        rsp_data_d            = mult_res;
        rsp_valid_d           = '0;
        rsp_valid_d[rsp_id_q] = 1'b1;
        state_d               = RESP;
      end
      RESP: begin
        // Only the owner's ready retires the response.
        if (rsp_ready[rsp_id_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDW'(NREQ - 1);
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a two-stage multiplier model and a response scoreboard.
module tb_mult_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [8*NREQ-1:0]   req_a;
  logic [8*NREQ-1:0]   req_b;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [7:0]          rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic [7:0]          mult_a;
  logic [7:0]          mult_b;
  logic [7:0]          mult_res;
  logic                busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  logic [7:0] exp_a = '0;
  logic [7:0] exp_b = '0;

  mult_share_arb #(.NREQ(NREQ), .MULT_LAT(2), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_res  (mult_res),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] prod(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    return p[7:0];
  endfunction

  // Two-cycle multiplier, no reset.
  logic [7:0] m1, m2;
  always @(posedge clk) begin
    m1 <= prod(mult_a, mult_b);
    m2 <= m1;
  end
  assign mult_res = m2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b);
    req_a[8*k +: 8] = a;
    req_b[8*k +: 8] = b;
    req_valid[k]    = 1'b1;
  endtask

  // Returns at the negedge following the accept edge.
  task automatic wait_grant(output int k);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant_timeout", 32'(n < 50), 1);
    k = 0;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) k = i;
    exp_a = req_a[8*k +: 8];
    exp_b = req_b[8*k +: 8];
    @(negedge clk);
  endtask

  task automatic wait_rsp(output int lat);
    exp_t e;
    lat = 0;
    while (rsp_valid == '0 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_timeout", 32'(lat < 50), 1);
    chk("sb_level", sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_id", rsp_id, e.id);
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_valid_onehot", rsp_valid, 32'(1) << e.id);
    end
  endtask

  // Continuous properties sampled away from the active edge.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      chk("ready_in_reset", req_ready, 0);
    end else begin
      chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
      if (busy) begin
        chk("hold_mult_a", mult_a, exp_a);
        chk("hold_mult_b", mult_b, exp_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] s_a [3];
  logic [7:0] s_b [3];
  logic [7:0] s_p [3];

  initial begin
    int k;
    int lat;
    s_a = '{8'hFD, 8'hFC, 8'h07};
    s_b = '{8'h05, 8'hFA, 8'hFE};
    s_p = '{8'hF1, 8'h18, 8'hF2};

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Single op
    rsp_ready = '1;
    set_req(0, 8'd3, 8'd5);
    push_exp(0, 8'h0F);
    wait_grant(k);
    chk("single_gnt", k, 0);
    req_valid[0] = 1'b0;
    chk("single_busy", busy, 1);
    wait_rsp(lat);
    chk("single_lat", lat, 3);
    @(negedge clk);
    chk("single_busy_drop", busy, 0);
    chk("single_rsp_clear", rsp_valid, 0);

    // Signed ops on requester 2
    for (int i = 0; i < 3; i++) begin
      set_req(2, s_a[i], s_b[i]);
      push_exp(2, s_p[i]);
      wait_grant(k);
      chk("signed_gnt", k, 2);
      req_valid[2] = 1'b0;
      wait_rsp(lat);
      chk("signed_lat", lat, 3);
      @(negedge clk);
    end

    // Backpressure on requester 1 with requester 3 waiting
    rsp_ready = '0;
    set_req(1, 8'd6, 8'd7);
    push_exp(1, 8'h2A);
    wait_grant(k);
    chk("bp_gnt", k, 1);
    req_valid[1] = 1'b0;
    set_req(3, 8'd2, 8'hFF);
    wait_rsp(lat);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_hold", rsp_valid, 4'b0010);
      chk("bp_data_hold", rsp_data, 8'h2A);
      chk("bp_id_hold", rsp_id, 1);
      chk("bp_no_ready", req_ready, 0);
    end
    rsp_ready = 4'b0010;
    @(negedge clk);
    chk("bp_single_hs", rsp_valid, 0);
    rsp_ready = '1;
    push_exp(3, 8'hFE);
    wait_grant(k);
    chk("bp_next_gnt", k, 3);
    req_valid[3] = 1'b0;
    wait_rsp(lat);
    @(negedge clk);

    // Round-robin with all requesters asserted
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(i + 1), 8'(i + 2));
    for (int op = 0; op < 8; op++) begin
      push_exp(op % 4, prod(8'(op % 4 + 1), 8'(op % 4 + 2)));
      wait_grant(k);
      chk("rr_gnt", k, op % 4);
      wait_rsp(lat);
    end
    req_valid = '0;
    @(negedge clk);

    // Ready from the wrong requester is ignored
    rsp_ready = 4'b0001;
    set_req(2, 8'd9, 8'd3);
    push_exp(2, 8'h1B);
    wait_grant(k);
    req_valid[2] = 1'b0;
    wait_rsp(lat);
    repeat (4) begin
      @(negedge clk);
      chk("wrong_owner_hold", rsp_valid, 4'b0100);
    end
    rsp_ready = 4'b0100;
    @(negedge clk);
    chk("owner_retire", rsp_valid, 0);
    chk("owner_busy", busy, 0);

    // Reset in the middle of an op
    rsp_ready = '1;
    set_req(3, 8'd5, 8'd5);
    wait_grant(k);
    chk("rst_mid_gnt", k, 3);
    req_valid[3] = 1'b0;
    rst = 1'b1;
    set_req(1, 8'd4, 8'd4);
    set_req(3, 8'd3, 8'd3);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    push_exp(1, 8'h10);
    wait_grant(k);
    chk("rst_mid_next_gnt", k, 1);
    req_valid[1] = 1'b0;
    wait_rsp(lat);
    chk("rst_mid_lat", lat, 3);
    push_exp(3, 8'h09);
    wait_grant(k);
    chk("rst_mid_gnt3", k, 3);
    req_valid[3] = 1'b0;
    wait_rsp(lat);
    @(negedge clk);
    chk("end_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
Shares one instance of the team's signed 8-bit two-cycle multiplier among NREQ requesters. Round-robin arbitration picks one requester and holds its operands stable on the multiplier inputs for the whole multiplier latency. The block then captures the 8-bit product and returns it over a per-requester valid/ready response channel. It sits between the requesting datapath blocks and a single external multiplier instance, which has no reset.

Parameters:
NREQ, 4, number of requesters (2..8)
MULT_LAT, 2, multiplier latency in clock edges from operand sampling to valid product; operands must stay stable across all MULT_LAT edges
IDW, 2, width of rsp_id, equal to ceil(log2(NREQ))

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  request valid, one bit per requester
req_ready  out  NREQ  request accept; one-hot or zero
req_a  in  8*NREQ  operand a, signed two's complement; requester k uses bits [8k+7:8k]
req_b  in  8*NREQ  operand b, same packing as req_a
rsp_valid  out  NREQ  response valid; one-hot or zero
rsp_ready  in  NREQ  response accept, per requester
rsp_data  out  8  product, shared by all requesters
rsp_id  out  IDW  index of the requester that owns rsp_data
mult_a  out  8  to multiplier input a
mult_b  out  8  to multiplier input b
mult_res  in  8  from multiplier result
busy  out  1  high in any state other than IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; rr_ptr=NREQ-1, so requester 0 has top priority first; req_ready=0; rsp_valid=0; rsp_data=0; rsp_id=0; mult_a=0; mult_b=0; busy=0.
- While rst is high, req_ready is forced to 0.
- FSM states: IDLE, BUSY, CAPT, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid=1, scanning from rr_ptr+1 upward with wrap-around.
  - req_ready is driven combinationally, only for the granted requester, and only in IDLE.
  - On the accept edge (valid & ready): latch req_a/req_b into mult_a/mult_b; latch the index into rsp_id; set rr_ptr to that index; clear cnt; go to BUSY.
  - With no req_valid: stay in IDLE; rr_ptr is unchanged.
- BUSY:
  - mult_a/mult_b are held constant.
  - cnt increments each cycle.
  - Move to CAPT on the edge where cnt==MULT_LAT-1, i.e. after MULT_LAT cycles.
- CAPT:
  - Exactly one cycle.
  - On its closing edge: rsp_data<=mult_res; rsp_valid[rsp_id]<=1; go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready[rsp_id]=1.
  - On that edge: rsp_valid<=0; go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- Latency, for MULT_LAT=2:
  - Accept edge E0; rsp_valid is visible after E0+3 (MULT_LAT+1 edges).
  - Minimum issue interval is MULT_LAT+3 cycles, because no new accept happens in the same cycle as a response handshake.
- mult_a/mult_b keep their last operands after the operation ends. They change only on an accept edge or on reset.
- Requester rules:
  - A requester must hold req_valid, req_a and req_b stable until accepted.
  - If a requester drops req_valid before acceptance, it is simply skipped.
  - A request that arrives while busy waits; it is never lost or reordered against the round-robin order.
- Arithmetic: the product is the 8-bit signed result as delivered by mult_res and is passed through unchanged. The block does no sign handling or truncation of its own. Operand value -128 is not supported by the multiplier; the result is don't-care.
- Reset mid-operation, in BUSY, CAPT or RESP:
  - The in-flight operation is discarded and no rsp_valid is produced for it.
  - rr_ptr returns to NREQ-1.
  - The stale multiplier output is never captured.
- Simultaneous requests: exactly one grant per accept, so req_ready is never multi-hot.

Test Plan:
- Single op: req 0 sends a=3, b=5 with rsp_ready=1 -> rsp_valid[0] rises exactly 3 edges after the accept edge; rsp_data=0x0F; rsp_id=0; busy drops the cycle after the response handshake.
- Signed ops: req 2 sends -3*5, then -4*-6, then 7*-2 -> rsp_data=0xF1, 0x18, 0xF2; mult_a/mult_b stay constant through every BUSY and CAPT cycle.
- Round-robin: all four req_valid held high, 8 ops -> grant order 0,1,2,3,0,1,2,3; req_ready is never multi-hot; each rsp_id matches its grant.
- Backpressure: rsp_ready[1] held low for 5 cycles in RESP -> rsp_valid[1], rsp_data and rsp_id are stable; req_ready stays 0 for all requesters; a single response handshake occurs when rsp_ready rises.
- Reset mid-op: rst pulsed for 1 cycle during BUSY of a req 3 op -> no rsp_valid for that op; busy=0 after reset; with reqs 1 and 3 pending, the next grant goes to req 1.
- Wrong-owner ready: rsp_ready[0]=1 while req 2's response is pending -> the response is held, and retires only on rsp_ready[2].
